gcd_engine: RTL and testbench
=============================

GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand and result width in bits (minimum 2).
REQ-002 SHALL have parameter TAG_WIDTH, default 4, width of the request tag carried from input to result.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port nreset_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous abort; returns the engine to IDLE.
REQ-006 SHALL have port in_valid_i  input  1  request valid.
REQ-007 SHALL have port in_ready_o  output  1  engine can accept a request.
REQ-008 SHALL have port operand_a_i  input  DATA_WIDTH  unsigned operand A.
REQ-009 SHALL have port operand_b_i  input  DATA_WIDTH  unsigned operand B.
REQ-010 SHALL have port tag_i  input  TAG_WIDTH  request tag.
REQ-011 SHALL have port out_valid_o  output  1  result valid.
REQ-012 SHALL have port out_ready_i  input  1  consumer accepts the result.
REQ-013 SHALL have port gcd_o  output  DATA_WIDTH  greatest common divisor.
REQ-014 SHALL have port tag_o  output  TAG_WIDTH  tag of the request that produced gcd_o.

Function
REQ-015 SHALL implement states IDLE, COMPUTE, DONE.
REQ-016 Accept: in_valid_i && in_ready_o at a rising edge; load A, B and tag into registers; go to COMPUTE.
REQ-017 SHALL drive in_ready_o = (state==IDLE) || (state==DONE && out_ready_i), i.e. back-to-back acceptance in the same cycle the previous result is taken.
REQ-018 COMPUTE, per cycle: if A==0 or B==0, capture result = A|B, go to DONE; else if A>=B then A<=A-B; else B<=B-A.
REQ-019 Subtraction SHALL be a DATA_WIDTH+1-bit unsigned compare/subtract; no wrap-around is permitted.
REQ-020 Latency: out_valid_o rises N+1 edges after the accept edge, where N is the number of subtraction steps.
REQ-021 gcd(0,0)=0, gcd(x,0)=gcd(0,x)=x, each with N=0 (one-cycle latency).
REQ-022 DONE: out_valid_o=1; gcd_o and tag_o stable until out_ready_i is seen high at an edge.
REQ-023 DONE with out_ready_i=1: go to IDLE, or to COMPUTE if a new request is accepted at the same edge.
REQ-024 out_valid_o SHALL be 0 in IDLE and COMPUTE.
REQ-025 Inputs changing while in COMPUTE or DONE SHALL have no effect.
REQ-026 clear_i=1 at an edge: state to IDLE and out_valid_o to 0, overriding any other event that edge; gcd_o and tag_o hold their last values; no request is accepted that edge.

Reset
REQ-027 nreset_i low SHALL asynchronously force state IDLE; A, B, gcd_o, tag_o to 0; out_valid_o 0.
REQ-028 in_ready_o SHALL read 1 during and immediately after reset.
REQ-029 Reset asserted mid-COMPUTE SHALL discard the operation with no result produced.

Configuration
REQ-030 Macro GCD_ITER_COUNT_EN defined: add output iter_count_o (DATA_WIDTH bits) = N of the current result, saturating at all-ones, valid with out_valid_o, reset to 0, cleared on each accept.
REQ-031 Macro GCD_ITER_COUNT_EN undefined: iter_count_o and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-032 Accept A=12, B=8, tag=3 -> out_valid_o 4 edges after accept, gcd_o=4, tag_o=3, iter_count_o=3.
REQ-033 Accept A=0, B=0, then A=7, B=0 -> gcd_o=0 then 7, each with 1-cycle latency.
REQ-034 Result (21,14) held with out_ready_i=0 for 5 cycles -> gcd_o=7 stable and in_ready_o=0; out_ready_i=1 with in_valid_i=1 (9,6) -> same-edge accept, next gcd_o=3.
REQ-035 clear_i pulsed during COMPUTE of (65535,1) -> IDLE next edge, out_valid_o never rises, in_ready_o=1.
REQ-036 nreset_i dropped mid-COMPUTE -> immediate IDLE, all outputs 0; next request (10,4) -> gcd_o=2.
REQ-037 Random operands against reference model, both macro settings -> gcd_o matches, latency per REQ-020.

Source files
------------

// File: rtl/gcd_engine.sv
// Subtractive GCD engine with a valid/ready request port and a held result port.
// Optional iter_count_o (subtraction steps of the current result) under `define GCD_ITER_COUNT_EN.
module gcd_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] gcd_o,
    output logic [TAG_WIDTH-1:0]  tag_o
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [DATA_WIDTH-1:0] iter_count_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_DONE
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [TAG_WIDTH-1:0]  tag_q;

    logic [DATA_WIDTH:0]   a_minus_b;
    logic [DATA_WIDTH-1:0] b_minus_a;
    logic                  a_ge_b;
    logic                  operand_zero;
    logic                  accept;

    // The extra top bit is the borrow: set exactly when a_q < b_q, so no step can wrap.
    always_comb begin
        a_minus_b    = {1'b0, a_q} - {1'b0, b_q};
        a_ge_b       = ~a_minus_b[DATA_WIDTH];
        b_minus_a    = b_q - a_q;
        operand_zero = (a_q == '0) || (b_q == '0);
    end

    assign in_ready_o = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready_i);
    assign accept     = in_valid_i && in_ready_o && !clear_i;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            gcd_o       <= '0;
            tag_o       <= '0;
            out_valid_o <= 1'b0;
        end else if (clear_i) begin
            // Abort wins over everything; the last result stays visible on gcd_o/tag_o.
            state_q     <= ST_IDLE;
            out_valid_o <= 1'b0;
        end else if (accept) begin
            a_q         <= operand_a_i;
            b_q         <= operand_b_i;
            tag_q       <= tag_i;
            out_valid_o <= 1'b0;
            state_q     <= ST_COMPUTE;
        end else begin
            case (state_q)
                ST_COMPUTE: begin
                    if (operand_zero) begin
                        gcd_o       <= a_q | b_q;
                        tag_o       <= tag_q;
                        out_valid_o <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (a_ge_b) begin
                        a_q <= a_minus_b[DATA_WIDTH-1:0];
                    end else begin
                        b_q <= b_minus_a;
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef GCD_ITER_COUNT_EN
    logic [DATA_WIDTH-1:0] iter_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            iter_q <= '0;
        end else if (accept) begin
            iter_q <= '0;
        end else if (!clear_i && (state_q == ST_COMPUTE) && !operand_zero && (iter_q != '1)) begin
            iter_q <= iter_q + 1'b1;
        end
    end

    assign iter_count_o = iter_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Directed plus randomized bench for gcd_engine; expected results and latencies
// come from a Euclidean-division reference model.
module tb_gcd_engine;

    localparam int W = 16;
    localparam int T = 4;
    localparam int unsigned MAX_CNT = (1 << W) - 1;

    logic         clk_i = 1'b0;
    logic         nreset_i;
    logic         clear_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] operand_a_i;
    logic [W-1:0] operand_b_i;
    logic [T-1:0] tag_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] gcd_o;
    logic [T-1:0] tag_o;
`ifdef GCD_ITER_COUNT_EN
    logic [W-1:0] iter_count_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    gcd_engine #(.DATA_WIDTH(W), .TAG_WIDTH(T)) dut (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .gcd_o       (gcd_o),
        .tag_o       (tag_o)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_count_o(iter_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    // Each Euclidean quotient equals the number of subtractions that division replaces.
    function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                    output int unsigned g, output int unsigned n);
        n = 0;
        while (a != 0 && b != 0) begin
            if (a >= b) begin
                n += a / b;
                a = a % b;
            end else begin
                n += b / a;
                b = b % a;
            end
        end
        g = a | b;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic accept_req(input int unsigned a, input int unsigned b, input int unsigned tag);
        check("in_ready_before_accept", in_ready_o, 1);
        in_valid_i  = 1'b1;
        operand_a_i = W'(a);
        operand_b_i = W'(b);
        tag_i       = T'(tag);
        tick();
        in_valid_i = 1'b0;
    endtask

    // Waits for the result while scrambling the request inputs, then checks value, tag and latency.
    task automatic expect_result(input int unsigned a, input int unsigned b, input int unsigned tag,
                                 input string name);
        int unsigned g, n;
        int cyc = 0;
        bit seen = 0;
        ref_gcd(a, b, g, n);
        for (int i = 0; i < int'(n) + 8 && !seen; i++) begin
            in_valid_i  = 1'($urandom_range(0, 1));
            operand_a_i = W'($urandom);
            operand_b_i = W'($urandom);
            tag_i       = T'($urandom);
            tick();
            cyc++;
            if (out_valid_o === 1'b1) seen = 1;
        end
        in_valid_i = 1'b0;
        check({name, "_latency"}, seen ? cyc : 0, n + 1);
        check({name, "_gcd"}, gcd_o, g);
        check({name, "_tag"}, tag_o, tag);
`ifdef GCD_ITER_COUNT_EN
        check({name, "_iter"}, iter_count_o, (n > MAX_CNT) ? MAX_CNT : n);
`endif
    endtask

    task automatic consume();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check("valid_drops_after_take", out_valid_o, 0);
    endtask

    initial begin
        bit rose;
        nreset_i    = 1'b0;
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        operand_a_i = '0;
        operand_b_i = '0;
        tag_i       = '0;

        #12;
        check("rst_in_ready", in_ready_o, 1);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_gcd", gcd_o, 0);
        check("rst_tag", tag_o, 0);
`ifdef GCD_ITER_COUNT_EN
        check("rst_iter", iter_count_o, 0);
`endif
        @(negedge clk_i);
        nreset_i = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready_o, 1);
        tick();

        // Reference example and zero-operand cases.
        accept_req(12, 8, 3);
        expect_result(12, 8, 3, "a12_b8");
        consume();
        accept_req(0, 0, 1);
        expect_result(0, 0, 1, "a0_b0");
        consume();
        accept_req(7, 0, 2);
        expect_result(7, 0, 2, "a7_b0");
        consume();
        accept_req(0, 9, 5);
        expect_result(0, 9, 5, "a0_b9");
        consume();

        // Back-pressure hold, then same-edge take and accept.
        accept_req(21, 14, 6);
        expect_result(21, 14, 6, "a21_b14");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_gcd", gcd_o, 7);
            check("hold_tag", tag_o, 6);
            check("hold_valid", out_valid_o, 1);
            check("hold_in_ready", in_ready_o, 0);
        end
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        operand_a_i = W'(9);
        operand_b_i = W'(6);
        tag_i       = T'(9);
        #1;
        check("same_edge_in_ready", in_ready_o, 1);
        tick();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        check("same_edge_valid_low", out_valid_o, 0);
        expect_result(9, 6, 9, "a9_b6");
        consume();

        // Abort mid-compute: result registers keep the previous result.
        accept_req(65535, 1, 4);
        repeat (10) tick();
        check("long_busy_valid", out_valid_o, 0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clear_in_ready", in_ready_o, 1);
        check("clear_valid", out_valid_o, 0);
        check("clear_gcd_held", gcd_o, 3);
        check("clear_tag_held", tag_o, 9);
        rose = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid_o !== 1'b0) rose = 1;
        end
        check("clear_no_result", rose, 0);

        // clear_i blocks an accept at the same edge.
        clear_i     = 1'b1;
        in_valid_i  = 1'b1;
        operand_a_i = W'(5);
        operand_b_i = W'(5);
        tick();
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        rose = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid_o !== 1'b0) rose = 1;
        end
        check("clear_blocks_accept", rose, 0);
        check("clear_blocks_in_ready", in_ready_o, 1);

        // Asynchronous reset in the middle of a computation.
        accept_req(200, 1, 7);
        repeat (5) tick();
        #2;
        nreset_i = 1'b0;
        #1;
        check("async_rst_in_ready", in_ready_o, 1);
        check("async_rst_valid", out_valid_o, 0);
        check("async_rst_gcd", gcd_o, 0);
        check("async_rst_tag", tag_o, 0);
`ifdef GCD_ITER_COUNT_EN
        check("async_rst_iter", iter_count_o, 0);
`endif
        @(posedge clk_i);
        @(negedge clk_i);
        nreset_i = 1'b1;
        tick();
        accept_req(10, 4, 2);
        expect_result(10, 4, 2, "a10_b4");
        consume();

        // Random operands, kept to 8 bits so subtraction chains stay short.
        for (int k = 0; k < 40; k++) begin
            int unsigned ra, rb, rt;
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            rt = $urandom_range(0, (1 << T) - 1);
            accept_req(ra, rb, rt);
            expect_result(ra, rb, rt, "rand");
            consume();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
